// File: rtl/arbitro_escritura.sv
// Round-robin arbiter for the register file's single write port: two valid/ready
// requesters, registered write outputs, write-protect mask and a commit counter.
module arbitro_escritura #(
  parameter int          N         = 16,
  parameter logic [15:0] PROT_MASK = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [3:0]   a_sel,
  input  logic [N-1:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [3:0]   b_sel,
  input  logic [N-1:0] b_data,
  output logic         w,
  output logic [3:0]   select_register,
  output logic [N-1:0] s,
  output logic         err,
  output logic         last_grant,
  output logic [15:0]  wr_count
);

  logic         prio_q;
  logic         w_q, err_q, lg_q;
  logic [3:0]   sel_q;
  logic [N-1:0] s_q;
  logic [15:0]  cnt_q;

  logic         can_gnt, gnt_d, prot_d;
  logic [3:0]   gsel_d;
  logic [N-1:0] gdata_d;

  // prio_q = 0 favours A on contention, 1 favours B
  always_comb begin
    can_gnt = !rst && !stall;
    a_ready = can_gnt && a_valid && (!b_valid || !prio_q);
    b_ready = can_gnt && b_valid && (!a_valid ||  prio_q);
    gnt_d   = a_ready || b_ready;
    gsel_d  = b_ready ? b_sel  : a_sel;
    gdata_d = b_ready ? b_data : a_data;
    prot_d  = PROT_MASK[gsel_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      w_q    <= 1'b0;
      err_q  <= 1'b0;
      lg_q   <= 1'b0;
      sel_q  <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
    end else begin
      w_q   <= gnt_d && !prot_d;
      err_q <= gnt_d &&  prot_d;
      if (gnt_d) begin
        // rotation and last_grant track every grant, protected or not
        prio_q <= a_ready;
        lg_q   <= b_ready;
        if (!prot_d) begin
          sel_q <= gsel_d;
          s_q   <= gdata_d;
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  assign w               = w_q;
  assign err             = err_q;
  assign select_register = sel_q;
  assign s               = s_q;
  assign last_grant      = lg_q;
  assign wr_count        = cnt_q;

endmodule
